// File: rtl/glitch_pulse_gen.sv
// Trigger-to-pulse burst generator: arm, wait for a synchronised trig_in rising edge,
// count a delay, then emit cfg_count pulses. Optional armed timeout under GLITCH_TIMEOUT_EN.
`timescale 1ns/100ps

module glitch_pulse_gen #(
    parameter int unsigned DLY_W = 32,
    parameter int unsigned WID_W = 16,
    parameter int unsigned CNT_W = 8
`ifdef GLITCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2**24
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig_in,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [WID_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             armed,
    output logic             busy,
    output logic             glitch_out,
    output logic             done
`ifdef GLITCH_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    // One down-counter serves delay, pulse-high and gap phases.
    localparam int unsigned CTR_W = (DLY_W > WID_W) ? DLY_W : WID_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [WID_W-1:0]   wid_m1_q, wid_m1_d;
    logic [WID_W-1:0]   gap_m1_q, gap_m1_d;
    logic [CNT_W-1:0]   num_m1_q, num_m1_d;
    logic               fin_q, fin_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic               trig_rise_c;
    logic               armed_q, armed_d;
    logic               busy_q, busy_d;
    logic               glitch_q, glitch_d;
    logic               done_q, done_d;

`ifdef GLITCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               tmo_fire_d;
    logic               timeout_q, timeout_d;
`endif

    assign trig_rise_c = sync2_q & ~sync3_q;

    // Trigger synchroniser plus edge-detect flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= trig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and datapath updates; abort overrides everything else.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        dly_d    = dly_q;
        wid_m1_d = wid_m1_q;
        gap_m1_d = gap_m1_q;
        num_m1_d = num_m1_q;
        fin_d    = 1'b0;
`ifdef GLITCH_TIMEOUT_EN
        tmo_d      = tmo_q;
        tmo_fire_d = 1'b0;
`endif
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d  = S_ARMED;
                        dly_d    = cfg_delay;
                        wid_m1_d = (cfg_width == '0) ? '0 : cfg_width - WID_W'(1);
                        gap_m1_d = (cfg_gap == '0) ? '0 : cfg_gap - WID_W'(1);
                        num_m1_d = (cfg_count == '0) ? '0 : cfg_count - CNT_W'(1);
`ifdef GLITCH_TIMEOUT_EN
                        tmo_d    = '0;
`endif
                    end
                end
                S_ARMED: begin
                    if (trig_rise_c) begin
                        state_d = S_DELAY;
                        cnt_d   = CTR_W'(dly_q);
                        pcnt_d  = num_m1_q;
                    end
`ifdef GLITCH_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d    = S_IDLE;
                        tmo_fire_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
`endif
                end
                S_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = S_PULSE;
                        cnt_d   = CTR_W'(wid_m1_q);
                    end else begin
                        cnt_d = cnt_q - CTR_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        if (pcnt_q == '0) begin
                            state_d = S_IDLE;
                            fin_d   = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = CTR_W'(gap_m1_q);
                            pcnt_d  = pcnt_q - CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CTR_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = S_PULSE;
                        cnt_d   = CTR_W'(wid_m1_q);
                    end else begin
                        cnt_d = cnt_q - CTR_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output register inputs. glitch_out trails the PULSE state by one cycle, so done and the
    // busy tail are aligned to the first low cycle after the final pulse.
    always_comb begin
        glitch_d = (state_q == S_PULSE) && !abort;
        done_d   = fin_q && !abort;
        armed_d  = (state_d == S_ARMED);
        busy_d   = (state_d == S_DELAY) || (state_d == S_PULSE) || (state_d == S_GAP) || fin_d;
`ifdef GLITCH_TIMEOUT_EN
        timeout_d = tmo_fire_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            pcnt_q   <= '0;
            dly_q    <= '0;
            wid_m1_q <= '0;
            gap_m1_q <= '0;
            num_m1_q <= '0;
            fin_q    <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            dly_q    <= dly_d;
            wid_m1_q <= wid_m1_d;
            gap_m1_q <= gap_m1_d;
            num_m1_q <= num_m1_d;
            fin_q    <= fin_d;
            armed_q  <= armed_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
            done_q   <= done_d;
        end
    end

`ifdef GLITCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign armed      = armed_q;
    assign busy       = busy_q;
    assign glitch_out = glitch_q;
    assign done       = done_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Self-checking bench for glitch_pulse_gen: directed table, randomized bursts against a
// waveform model, and hand-written abort/reset/ignore sequences.
`timescale 1ns/100ps

module tb_glitch_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        abort;
    logic        trig_in;
    logic [31:0] cfg_delay;
    logic [15:0] cfg_width;
    logic [15:0] cfg_gap;
    logic [7:0]  cfg_count;
    logic        armed;
    logic        busy;
    logic        glitch_out;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #2.5 clk = ~clk;

`ifdef GLITCH_TIMEOUT_EN
    logic timeout;
    glitch_pulse_gen #(.TIMEOUT_CYCLES(100)) u_dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_in(trig_in),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
        .armed(armed), .busy(busy), .glitch_out(glitch_out), .done(done), .timeout(timeout)
    );
`else
    glitch_pulse_gen u_dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_in(trig_in),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
        .armed(armed), .busy(busy), .glitch_out(glitch_out), .done(done)
    );
`endif

    typedef struct {
        int d;
        int w;
        int g;
        int c;
        int exp_first;
        int exp_done;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp1(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    // Expected glitch level n cycles after the first edge that samples trig_in high.
    function automatic int m_glitch(input int n, input int d, input int w, input int g, input int c);
        int first, span;
        first = d + 4;
        span  = clamp1(w) + clamp1(g);
        for (int k = 0; k < clamp1(c); k++) begin
            if (n >= first + k * span && n < first + k * span + clamp1(w)) return 1;
        end
        return 0;
    endfunction

    function automatic int m_done(input int d, input int w, input int g, input int c);
        return d + 4 + clamp1(c) * clamp1(w) + (clamp1(c) - 1) * clamp1(g);
    endfunction

    task automatic scramble_cfg();
        cfg_delay = $urandom;
        cfg_width = 16'($urandom);
        cfg_gap   = 16'($urandom);
        cfg_count = 8'($urandom);
    endtask

    task automatic arm_cfg(input int d, input int w, input int g, input int c);
        @(posedge clk); #1;
        cfg_delay = 32'(d);
        cfg_width = 16'(w);
        cfg_gap   = 16'(g);
        cfg_count = 8'(c);
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        scramble_cfg();
    endtask

    task automatic settle_trig_low();
        @(posedge clk); #1;
        trig_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Arms, fires the trigger and compares every output each cycle against the model.
    // rearm: extra arm strobe while ARMED; arm_at: arm strobe at cycle n during the burst.
    task automatic run_burst(input int d, input int w, input int g, input int c,
                             input bit rearm, input int arm_at,
                             output int first_hi, output int done_at);
        int dn;
        arm_cfg(d, w, g, c);
        if (rearm) begin
            arm = 1'b1;
            cfg_delay = 32'd3;
            cfg_width = 16'd7;
            @(posedge clk); #1;
            arm = 1'b0;
        end
        chk("armed_before_trig", int'(armed), 1);
        trig_in  = 1'b1;
        dn       = m_done(d, w, g, c);
        first_hi = -1;
        done_at  = -1;
        @(posedge clk);
        for (int n = 0; n <= dn + 3; n++) begin
            @(negedge clk);
            chk("glitch", int'(glitch_out), m_glitch(n, d, w, g, c));
            chk("done", int'(done), int'(n == dn));
            chk("busy", int'(busy), int'(n >= 2 && n < dn));
            chk("armed", int'(armed), int'(n < 2));
            if (glitch_out && first_hi < 0) first_hi = n;
            if (done && done_at < 0) done_at = n;
            if (n == arm_at) begin
                arm = 1'b1;
                cfg_delay = 32'd0;
                cfg_width = 16'd9;
                cfg_count = 8'd1;
            end else begin
                arm = 1'b0;
            end
        end
        arm = 1'b0;
        settle_trig_low();
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (glitch_out || done || busy || armed) seen = 1;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   fh, da, d, w, g, c, waited;

        vecs[0] = '{d: 10, w: 3, g: 0, c: 1, exp_first: 14, exp_done: 17};
        vecs[1] = '{d: 0,  w: 2, g: 4, c: 3, exp_first: 4,  exp_done: 18};
        vecs[2] = '{d: 0,  w: 0, g: 0, c: 0, exp_first: 4,  exp_done: 5};
        vecs[3] = '{d: 3,  w: 1, g: 2, c: 2, exp_first: 7,  exp_done: 11};
        vecs[4] = '{d: 1,  w: 4, g: 0, c: 2, exp_first: 5,  exp_done: 14};

        rst_n   = 1'b0;
        arm     = 1'b0;
        abort   = 1'b0;
        trig_in = 1'b0;
        scramble_cfg();
        #1;
        chk("reset_outputs", int'({armed, busy, glitch_out, done}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", int'({armed, busy, glitch_out, done}), 0);

        // Directed table.
        foreach (vecs[i]) begin
            run_burst(vecs[i].d, vecs[i].w, vecs[i].g, vecs[i].c, 1'b0, -1, fh, da);
            chk("table_first_high", fh, vecs[i].exp_first);
            chk("table_done_cycle", da, vecs[i].exp_done);
        end

        // Randomized bursts.
        for (int t = 0; t < 25; t++) begin
            d = int'($urandom_range(0, 30));
            w = int'($urandom_range(0, 6));
            g = int'($urandom_range(0, 6));
            c = int'($urandom_range(0, 4));
            run_burst(d, w, g, c, 1'b0, -1, fh, da);
        end

        // Arm while ARMED and arm while busy are both ignored.
        run_burst(5, 2, 3, 2, 1'b1, -1, fh, da);
        chk("rearm_armed_done", da, m_done(5, 2, 3, 2));
        run_burst(5, 2, 3, 2, 1'b0, 4, fh, da);
        chk("arm_busy_done", da, m_done(5, 2, 3, 2));

        // Trigger edge in IDLE does nothing.
        trig_in = 1'b1;
        check_quiet("trig_in_idle", 12);
        settle_trig_low();

        // Abort beats arm in the same cycle.
        arm = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        abort = 1'b0;
        chk("abort_beats_arm", int'(armed), 0);

        // Abort 500 cycles into a 1000-cycle delay.
        arm_cfg(1000, 3, 1, 1);
        trig_in = 1'b1;
        @(posedge clk);
        repeat (502) @(posedge clk);
        #1;
        chk("delay_busy_pre_abort", int'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_delay_state", int'({armed, busy, glitch_out, done}), 0);
        check_quiet("abort_delay_quiet", 1100);
        settle_trig_low();

        // Abort mid-pulse.
        arm_cfg(2, 8, 1, 2);
        trig_in = 1'b1;
        waited = 0;
        while (!glitch_out && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("pulse_seen_before_abort", int'(glitch_out), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_pulse_state", int'({armed, busy, glitch_out, done}), 0);
        check_quiet("abort_pulse_quiet", 30);
        settle_trig_low();

        // Async reset mid-pulse.
        arm_cfg(0, 20, 1, 1);
        trig_in = 1'b1;
        waited = 0;
        while (!glitch_out && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("pulse_seen_before_reset", int'(glitch_out), 1);
        #1 rst_n = 1'b0;
        trig_in = 1'b0;
        #0.5;
        chk("async_reset_drop", int'({armed, busy, glitch_out, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet("idle_after_mid_reset", 5);
        trig_in = 1'b1;
        check_quiet("trig_after_reset", 12);
        settle_trig_low();

`ifdef GLITCH_TIMEOUT_EN
        // Armed timeout with no trigger.
        arm_cfg(4, 1, 1, 1);
        waited = 0;
        while (!timeout && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("timeout_cycle", waited, 100);
        chk("timeout_armed_low", int'(armed), 0);
        @(posedge clk); #1;
        chk("timeout_one_cycle", int'(timeout), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
